// File: rtl/zynq_if_pkg.sv
// Shared types and field positions for the VDMA frame gate.
// Contents:
//   gate_state_t     sequencer state, encoding is visible in status_word[2:0]
//   CMD_*            bit positions inside the PS command word
//   STAT_*           field positions inside status_word
//   sat_inc12        12-bit saturating increment used by the geometry counters
package zynq_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARMED_RUN  = 3'd1,
    ST_RUN        = 3'd2,
    ST_ARMED_SNAP = 3'd3,
    ST_SNAP       = 3'd4
  } gate_state_t;

  localparam int CMD_START = 0;
  localparam int CMD_SNAP  = 1;
  localparam int CMD_STOP  = 2;
  localparam int CMD_CLR   = 31;
  localparam int CMD_N_MSB = 15;
  localparam int CMD_N_LSB = 8;

  localparam int STAT_STATE_MSB = 2;
  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_GATE      = 3;
  localparam int STAT_WERR      = 4;
  localparam int STAT_HERR      = 5;
  localparam int STAT_TMO       = 6;
  localparam int STAT_SNAP_MSB  = 15;
  localparam int STAT_SNAP_LSB  = 8;
  localparam int STAT_CNT_MSB   = 31;
  localparam int STAT_CNT_LSB   = 16;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/vid_geom_check.sv
// Frame geometry checker for the incoming video stream.
// Detects frame start (vsync rising edge) and VDE falling edges, measures
// each active-line length and the number of active lines per frame, and
// raises sticky width/height errors.
// Ports:
//   clk, rst_n     pixel clock, async active-low reset
//   clr            one-cycle clear of counters, errors and the first-SOF flag
//   vsync, vde     input timing
//   sof            combinational frame-start pulse (same cycle as the edge)
//   width_err      sticky: a line length differed from CAM_IMAGE_WIDTH
//   height_err     sticky: a frame line count differed from CAM_IMAGE_HEIGHT
module vid_geom_check #(
  parameter int CAM_IMAGE_WIDTH  = 640,
  parameter int CAM_IMAGE_HEIGHT = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic vsync,
  input  logic vde,
  output logic sof,
  output logic width_err,
  output logic height_err
);
  import zynq_if_pkg::*;

  logic        r_vs_d, r_vde_d;
  logic [11:0] r_pix, r_lines;
  logic        r_seen, r_werr, r_herr;
  logic        w_fall;

  assign sof        = vsync & ~r_vs_d;
  assign w_fall     = r_vde_d & ~vde;
  assign width_err  = r_werr;
  assign height_err = r_herr;

  // Nothing is judged until one frame start has been seen: the stream
  // before it is a partial frame after reset or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d  <= 1'b0;
      r_vde_d <= 1'b0;
      r_pix   <= '0;
      r_lines <= '0;
      r_seen  <= 1'b0;
      r_werr  <= 1'b0;
      r_herr  <= 1'b0;
    end else begin
      r_vs_d  <= vsync;
      r_vde_d <= vde;
      if (clr) begin
        r_pix   <= '0;
        r_lines <= '0;
        r_seen  <= 1'b0;
        r_werr  <= 1'b0;
        r_herr  <= 1'b0;
      end else begin
        if (vde)
          r_pix <= r_vde_d ? sat_inc12(r_pix) : 12'd1;
        if (sof) begin
          r_seen  <= 1'b1;
          r_lines <= w_fall ? 12'd1 : 12'd0;
          if (r_seen && (r_lines != 12'(CAM_IMAGE_HEIGHT)))
            r_herr <= 1'b1;
        end else if (w_fall) begin
          r_lines <= sat_inc12(r_lines);
        end
        if (w_fall && r_seen && (r_pix != 12'(CAM_IMAGE_WIDTH)))
          r_werr <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vid_frame_gate_ctrl.sv
// Frame-accurate gate and sequencer between the VDMA video output and the
// PL video sink. The PS issues start / stop / N-frame snapshot commands;
// the gate only changes on frame starts so the sink never sees torn frames.
// Optional watchdog: define VID_FRAME_GATE_TIMEOUT_EN to close the gate and
// return to IDLE when no frame start arrives for TIMEOUT_CYCLES while active.
// Ports:
//   PixelClk, vid_rstn         clock, async active-low reset
//   cmd_wr, cmd_word           command strobe and word
//                              [0]start [1]snap [2]stop [15:8]N [31]clear
//   vid_in_*                   input video (hsync, vsync, VDE, 24-bit data)
//   vid_out_*                  registered video, VDE/data gated
//   status_word                [2:0]state [3]gate [4]werr [5]herr [6]timeout
//                              [15:8]snap_left [31:16]frame_cnt
//   frame_done                 pulse for each completed gated frame
module vid_frame_gate_ctrl #(
  parameter int CAM_IMAGE_WIDTH  = 640,
  parameter int CAM_IMAGE_HEIGHT = 480,
  parameter int TIMEOUT_CYCLES   = 4000000
) (
  input  logic        PixelClk,
  input  logic        vid_rstn,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_word,
  input  logic        vid_in_hsync,
  input  logic        vid_in_vsync,
  input  logic        vid_in_VDE,
  input  logic [23:0] vid_in_data,
  output logic        vid_out_hsync,
  output logic        vid_out_vsync,
  output logic        vid_out_VDE,
  output logic [23:0] vid_out_data,
  output logic [31:0] status_word,
  output logic        frame_done
);
  import zynq_if_pkg::*;

  gate_state_t r_state;
  logic        r_gate, r_stop_pend, r_frame_done;
  logic [7:0]  r_snap_left;
  logic [15:0] r_frame_cnt;
  logic        r_hs, r_vs, r_vde;
  logic [23:0] r_data;

  logic        w_sof, w_werr, w_herr;
  logic        w_stop, w_snap, w_start, w_clr;
  logic [7:0]  w_n;
  logic        w_open, w_close, w_count, w_gate_nxt;
  logic        w_tmo, w_tmo_flag;
  logic        w_unused_cmd;

  // Priority stop > snap > start inside one word.
  assign w_stop  = cmd_wr & cmd_word[CMD_STOP];
  assign w_snap  = cmd_wr & cmd_word[CMD_SNAP] & ~w_stop;
  assign w_start = cmd_wr & cmd_word[CMD_START] & ~w_stop & ~cmd_word[CMD_SNAP];
  assign w_clr   = cmd_wr & cmd_word[CMD_CLR];
  assign w_n     = cmd_word[CMD_N_MSB:CMD_N_LSB];
  assign w_unused_cmd = ^{cmd_word[30:16], cmd_word[7:3]};

  vid_geom_check #(
    .CAM_IMAGE_WIDTH (CAM_IMAGE_WIDTH),
    .CAM_IMAGE_HEIGHT(CAM_IMAGE_HEIGHT)
  ) u_geom (
    .clk       (PixelClk),
    .rst_n     (vid_rstn),
    .clr       (w_clr),
    .vsync     (vid_in_vsync),
    .vde       (vid_in_VDE),
    .sof       (w_sof),
    .width_err (w_werr),
    .height_err(w_herr)
  );

  // Gate events are resolved in the SOF cycle itself so the pixel register
  // sees the new gate on the same edge. A stop arriving together with SOF
  // is evaluated first: in ARMED it cancels, in RUN/SNAP it closes now.
  always_comb begin
    w_open  = w_sof & ~w_stop &
              ((r_state == ST_ARMED_RUN) | (r_state == ST_ARMED_SNAP));
    w_close = w_sof & r_gate &
              (((r_state == ST_RUN)  & (r_stop_pend | w_stop)) |
               ((r_state == ST_SNAP) & ((r_snap_left == 8'd1) | r_stop_pend | w_stop)));
    // Every SOF seen with the gate already open completes one frame.
    w_count = w_sof & r_gate & ~w_tmo;
    w_gate_nxt = r_gate;
    if (w_open)  w_gate_nxt = 1'b1;
    if (w_close) w_gate_nxt = 1'b0;
    if (w_tmo)   w_gate_nxt = 1'b0;
  end

`ifdef VID_FRAME_GATE_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_tmo;

  assign w_tmo      = (r_state != ST_IDLE) & ~w_sof &
                      (r_wdog == 32'(TIMEOUT_CYCLES - 1));
  assign w_tmo_flag = r_tmo;

  always_ff @(posedge PixelClk or negedge vid_rstn) begin
    if (!vid_rstn) begin
      r_wdog <= '0;
      r_tmo  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) || w_sof) r_wdog <= '0;
      else                               r_wdog <= r_wdog + 32'd1;
      if (w_clr)      r_tmo <= 1'b0;
      else if (w_tmo) r_tmo <= 1'b1;
    end
  end
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_tmo      = 1'b0;
  assign w_tmo_flag = 1'b0;
`endif

  always_ff @(posedge PixelClk or negedge vid_rstn) begin
    if (!vid_rstn) begin
      r_state      <= ST_IDLE;
      r_gate       <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_snap_left  <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_gate       <= w_gate_nxt;
      r_frame_done <= w_count;
      if (w_clr)        r_frame_cnt <= '0;
      else if (w_count) r_frame_cnt <= r_frame_cnt + 16'd1;

      case (r_state)
        ST_IDLE: begin
          r_stop_pend <= 1'b0;
          if (w_snap) begin
            r_state     <= ST_ARMED_SNAP;
            r_snap_left <= (w_n == 8'd0) ? 8'd1 : w_n;
          end else if (w_start) begin
            r_state <= ST_ARMED_RUN;
          end
        end
        ST_ARMED_RUN: begin
          if (w_stop)     r_state <= ST_IDLE;
          else if (w_sof) r_state <= ST_RUN;
        end
        ST_ARMED_SNAP: begin
          if (w_stop) begin
            r_state     <= ST_IDLE;
            r_snap_left <= '0;
          end else if (w_sof) begin
            r_state <= ST_SNAP;
          end
        end
        ST_RUN: begin
          if (w_close) begin
            r_state     <= ST_IDLE;
            r_stop_pend <= 1'b0;
          end else if (w_stop) begin
            r_stop_pend <= 1'b1;
          end
        end
        ST_SNAP: begin
          if (w_close) begin
            r_state     <= ST_IDLE;
            r_snap_left <= '0;
            r_stop_pend <= 1'b0;
          end else begin
            if (w_sof)  r_snap_left <= r_snap_left - 8'd1;
            if (w_stop) r_stop_pend <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_tmo) begin
        r_state     <= ST_IDLE;
        r_snap_left <= '0;
        r_stop_pend <= 1'b0;
      end
    end
  end

  // One-cycle video path; syncs are never gated.
  always_ff @(posedge PixelClk or negedge vid_rstn) begin
    if (!vid_rstn) begin
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_vde  <= 1'b0;
      r_data <= '0;
    end else begin
      r_hs   <= vid_in_hsync;
      r_vs   <= vid_in_vsync;
      r_vde  <= vid_in_VDE & w_gate_nxt;
      r_data <= w_gate_nxt ? vid_in_data : 24'h0;
    end
  end

  assign vid_out_hsync = r_hs;
  assign vid_out_vsync = r_vs;
  assign vid_out_VDE   = r_vde;
  assign vid_out_data  = r_data;
  assign frame_done    = r_frame_done;

  always_comb begin
    status_word = '0;
    status_word[STAT_STATE_MSB:STAT_STATE_LSB] = r_state;
    status_word[STAT_GATE]                     = r_gate;
    status_word[STAT_WERR]                     = w_werr;
    status_word[STAT_HERR]                     = w_herr;
    status_word[STAT_TMO]                      = w_tmo_flag;
    status_word[STAT_SNAP_MSB:STAT_SNAP_LSB]   = r_snap_left;
    status_word[STAT_CNT_MSB:STAT_CNT_LSB]     = r_frame_cnt;
  end

endmodule

// File: tb/tb_vid_frame_gate_ctrl.sv
// Directed bench for vid_frame_gate_ctrl with an 8x4 image and a
// 200-cycle watchdog.
module tb_vid_frame_gate_ctrl;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int TMO = 200;

  logic        PixelClk = 1'b0;
  logic        vid_rstn;
  logic        cmd_wr;
  logic [31:0] cmd_word;
  logic        vid_in_hsync, vid_in_vsync, vid_in_VDE;
  logic [23:0] vid_in_data;
  logic        vid_out_hsync, vid_out_vsync, vid_out_VDE;
  logic [23:0] vid_out_data;
  logic [31:0] status_word;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int vde_cnt, fd_cnt, sync_bad, data_bad, leak;

  vid_frame_gate_ctrl #(
    .CAM_IMAGE_WIDTH (W),
    .CAM_IMAGE_HEIGHT(H),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .PixelClk     (PixelClk),
    .vid_rstn     (vid_rstn),
    .cmd_wr       (cmd_wr),
    .cmd_word     (cmd_word),
    .vid_in_hsync (vid_in_hsync),
    .vid_in_vsync (vid_in_vsync),
    .vid_in_VDE   (vid_in_VDE),
    .vid_in_data  (vid_in_data),
    .vid_out_hsync(vid_out_hsync),
    .vid_out_vsync(vid_out_vsync),
    .vid_out_VDE  (vid_out_VDE),
    .vid_out_data (vid_out_data),
    .status_word  (status_word),
    .frame_done   (frame_done)
  );

  always #5 PixelClk = ~PixelClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before the edge, outputs sampled 1 ns after it.
  task automatic step();
    @(posedge PixelClk);
    #1;
    if (vid_out_hsync !== vid_in_hsync || vid_out_vsync !== vid_in_vsync) sync_bad++;
    if (vid_out_VDE === 1'b1) begin
      vde_cnt++;
      if (vid_out_data !== vid_in_data) data_bad++;
    end else if (vid_out_data !== 24'h0) begin
      leak++;
    end
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cmd(input logic [31:0] w);
    cmd_wr   = 1'b1;
    cmd_word = w;
    step();
    cmd_wr   = 1'b0;
    cmd_word = '0;
  endtask

  task automatic zero_cnt();
    vde_cnt = 0; fd_cnt = 0; sync_bad = 0; data_bad = 0; leak = 0;
  endtask

  // One frame: vsync pulse, then nlines lines of W pixels (line short_ln has
  // W-1). A command word is issued on the first pixel of line cmd_ln.
  task automatic send_frame(input int nlines, input int short_ln,
                            input int cmd_ln, input logic [31:0] cw);
    int w;
    vid_in_vsync = 1'b1; step(); step();
    vid_in_vsync = 1'b0; step(); step();
    for (int l = 0; l < nlines; l++) begin
      w = (l == short_ln) ? W - 1 : W;
      for (int p = 0; p < w; p++) begin
        vid_in_VDE  = 1'b1;
        vid_in_data = {8'hA5, 8'(l), 8'(p)};
        if (l == cmd_ln && p == 0) begin
          cmd_wr   = 1'b1;
          cmd_word = cw;
        end
        step();
        cmd_wr   = 1'b0;
        cmd_word = '0;
      end
      vid_in_VDE   = 1'b0;
      vid_in_data  = '0;
      vid_in_hsync = 1'b1; step(); step();
      vid_in_hsync = 1'b0; step();
    end
  endtask

  task automatic frame();
    send_frame(H, -1, -1, 32'h0);
  endtask

  initial begin
    // Reset with busy inputs: outputs must stay 0.
    vid_rstn     = 1'b0;
    cmd_wr       = 1'b0;
    cmd_word     = '0;
    vid_in_hsync = 1'b1;
    vid_in_vsync = 1'b1;
    vid_in_VDE   = 1'b1;
    vid_in_data  = 24'hFFFFFF;
    repeat (3) @(posedge PixelClk);
    #1;
    check("rst_outputs", {4'h0, vid_out_hsync, vid_out_vsync, vid_out_VDE,
                          frame_done, vid_out_data}, 32'h0);
    check("rst_status", status_word, 32'h0);
    vid_in_hsync = 1'b0; vid_in_vsync = 1'b0; vid_in_VDE = 1'b0; vid_in_data = '0;
    @(negedge PixelClk);
    vid_rstn = 1'b1;
    zero_cnt();
    idle(4);

    // 1: three frames with no command, gate stays shut.
    repeat (3) frame();
    check("t1_vde_blocked", vde_cnt, 0);
    check("t1_sync_follow", sync_bad, 0);
    check("t1_status", status_word, 32'h0);
    check("t1_data_leak", leak, 0);

    // 2: start mid-frame 1, stop mid-frame 3.
    zero_cnt();
    send_frame(H, -1, 1, 32'h1);
    check("t2_armed", status_word[2:0], 3'd1);
    check("t2_vde_before_sof", vde_cnt, 0);
    frame();
    check("t2_run_gate", status_word[3:0], 4'b1010);
    send_frame(H, -1, 1, 32'h4);
    frame();
    check("t2_vde_frames", vde_cnt, 2 * W * H);
    check("t2_frame_done", fd_cnt, 2);
    check("t2_frame_cnt", status_word[31:16], 16'd2);
    check("t2_state_idle", status_word[3:0], 4'd0);
    check("t2_data", data_bad, 0);

    // 3: snapshot of 3 frames, then snapshot with N=0.
    zero_cnt();
    cmd(32'h0000_0302);
    check("t3_armed_snap", {status_word[15:8], 5'd0, status_word[2:0]}, {8'd3, 5'd0, 3'd3});
    frame();
    check("t3_snap_left_a", {status_word[15:8], 5'd0, status_word[2:0]}, {8'd3, 5'd0, 3'd4});
    frame();
    check("t3_snap_left_b", status_word[15:8], 8'd2);
    frame();
    check("t3_snap_left_c", status_word[15:8], 8'd1);
    frame();
    check("t3_snap_done", {status_word[15:8], status_word[3:0]}, 12'h000);
    check("t3_vde_n3", vde_cnt, 3 * W * H);
    check("t3_fd_n3", fd_cnt, 3);
    zero_cnt();
    cmd(32'h0000_0002);
    check("t3_n0_as_1", status_word[15:8], 8'd1);
    frame();
    frame();
    check("t3_vde_n0", vde_cnt, W * H);
    check("t3_frame_cnt", status_word[31:16], 16'd6);
    check("t3_idle", status_word[2:0], 3'd0);

    // 4: geometry errors and clear.
    send_frame(H, 2, -1, 32'h0);
    check("t4_width_err", status_word[5:4], 2'b01);
    send_frame(H + 1, -1, -1, 32'h0);
    check("t4_height_pending", status_word[5], 1'b0);
    frame();
    check("t4_height_err", status_word[5:4], 2'b11);
    cmd(32'h8000_0000);
    check("t4_clear", {status_word[31:16], 10'd0, status_word[5:0]}, 32'h0);
    frame();
    check("t4_no_recheck", status_word[5:4], 2'b00);

    // 5: stop wins over snap/start; start then stop before SOF.
    cmd(32'h0000_0007);
    check("t5_stop_wins", {status_word[15:8], status_word[2:0]}, 11'd0);
    cmd(32'h0000_0001);
    check("t5_start_armed", status_word[2:0], 3'd1);
    cmd(32'h0000_0004);
    check("t5_stop_cancel", status_word[2:0], 3'd0);
    zero_cnt();
    frame();
    check("t5_no_vde", vde_cnt, 0);
    check("t5_no_fd", fd_cnt, 0);

    // 6: watchdog with vsync held low after the gate opened.
    cmd(32'h0000_0001);
    frame();
    check("t6_running", status_word[3:0], 4'b1010);
    zero_cnt();
    idle(100);
    check("t6_before_tmo", status_word[6:0], 7'b000_1010);
    idle(100);
`ifdef VID_FRAME_GATE_TIMEOUT_EN
    check("t6_timeout", status_word[6:0], 7'b100_0000);
    check("t6_no_fd", fd_cnt, 0);
`else
    check("t6_no_watchdog", status_word[6:0], 7'b000_1010);
    cmd(32'h0000_0004);
    frame();
    check("t6_stopped", status_word[3:0], 4'd0);
`endif
    check("t6_sync_follow", sync_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
